// File: rtl/dsp_fft_frame_feeder.sv
// Frame feeder for the iterative FFT core: gathers a sample stream into FFT_N-sample
// frames in a ping-pong buffer and bursts each completed frame to the core.
`timescale 1ns/1ps
module dsp_fft_frame_feeder #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FFT_N  = 8,
  parameter int unsigned LOG2N  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2*DATA_W-1:0]   s_data,
  input  logic                  s_vld,
  input  logic                  s_last,
  output logic                  s_rdy,
  output logic [2*DATA_W-1:0]   fft_din,
  output logic                  fft_din_vld,
  input  logic                  fft_din_busy,
  output logic [15:0]           frame_cnt
);

  localparam int unsigned SAMPLE_W = 2 * DATA_W;
  localparam int unsigned CNT_W    = 16;
  localparam logic [LOG2N-1:0] LAST_PTR = LOG2N'(FFT_N - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_BURST} state_e;

  state_e                state_q, state_d;
  logic [LOG2N-1:0]      wr_ptr_q, wr_ptr_d;
  logic                  wr_sel_q, wr_sel_d;
  logic                  pad_q, pad_d;
  logic [1:0]            full_q, full_d;
  logic                  s_rdy_q, s_rdy_d;
  logic                  rd_sel_q, rd_sel_d;
  logic [LOG2N-1:0]      rd_addr_q, rd_addr_d;
  logic [SAMPLE_W-1:0]   fft_din_q, fft_din_d;
  logic                  fft_din_vld_q, fft_din_vld_d;
  logic [CNT_W-1:0]      frame_cnt_q, frame_cnt_d;

  logic [SAMPLE_W-1:0]   mem_q [0:1][0:FFT_N-1];
  logic                  wr_en;
  logic [SAMPLE_W-1:0]   wr_data;
  logic [SAMPLE_W-1:0]   rd_word;
  logic                  set_full;
  logic                  clr_full;
  logic                  accept;

  assign accept = s_vld & s_rdy_q;

  // Write side: accept samples, or zero-fill the tail of a frame closed early by s_last
  always_comb begin
    wr_en    = 1'b0;
    wr_data  = '0;
    wr_ptr_d = wr_ptr_q;
    wr_sel_d = wr_sel_q;
    pad_d    = pad_q;
    set_full = 1'b0;
    if (pad_q || accept) begin
      wr_en   = 1'b1;
      wr_data = pad_q ? '0 : s_data;
      if (wr_ptr_q == LAST_PTR) begin
        set_full = 1'b1;
        wr_ptr_d = '0;
        wr_sel_d = ~wr_sel_q;
        pad_d    = 1'b0;
      end else begin
        wr_ptr_d = wr_ptr_q + LOG2N'(1);
        if (!pad_q && s_last) begin
          pad_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rd_word = mem_q[rd_sel_q][rd_addr_q];
  end

  // Read FSM: wait for a full bank and an idle core, then stream FFT_N beats unbroken
  always_comb begin
    state_d       = state_q;
    rd_sel_d      = rd_sel_q;
    rd_addr_d     = rd_addr_q;
    fft_din_d     = fft_din_q;
    fft_din_vld_d = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    clr_full      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (full_q[rd_sel_q] && !fft_din_busy) begin
          state_d   = ST_ARM;
          rd_addr_d = '0;
        end
      end
      ST_ARM: begin
        state_d       = ST_BURST;
        fft_din_d     = rd_word;
        fft_din_vld_d = 1'b1;
        rd_addr_d     = rd_addr_q + LOG2N'(1);
      end
      ST_BURST: begin
        // rd_addr wraps to 0 exactly while the final beat is on the output
        if (rd_addr_q == '0) begin
          state_d     = ST_IDLE;
          clr_full    = 1'b1;
          rd_sel_d    = ~rd_sel_q;
          frame_cnt_d = frame_cnt_q + CNT_W'(1);
        end else begin
          fft_din_d     = rd_word;
          fft_din_vld_d = 1'b1;
          rd_addr_d     = rd_addr_q + LOG2N'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bank flags; set and clear always hit different banks, so both apply together
  always_comb begin
    full_d = full_q;
    if (clr_full) begin
      full_d[rd_sel_q] = 1'b0;
    end
    if (set_full) begin
      full_d[wr_sel_q] = 1'b1;
    end
    s_rdy_d = ~full_d[wr_sel_d] & ~pad_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      wr_sel_q      <= 1'b0;
      pad_q         <= 1'b0;
      full_q        <= '0;
      s_rdy_q       <= 1'b0;
      rd_sel_q      <= 1'b0;
      rd_addr_q     <= '0;
      fft_din_q     <= '0;
      fft_din_vld_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      wr_sel_q      <= wr_sel_d;
      pad_q         <= pad_d;
      full_q        <= full_d;
      s_rdy_q       <= s_rdy_d;
      rd_sel_q      <= rd_sel_d;
      rd_addr_q     <= rd_addr_d;
      fft_din_q     <= fft_din_d;
      fft_din_vld_q <= fft_din_vld_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  // Sample storage carries no reset; the full flags alone decide what is valid
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_sel_q][wr_ptr_q] <= wr_data;
    end
  end

  assign s_rdy       = s_rdy_q;
  assign fft_din     = fft_din_q;
  assign fft_din_vld = fft_din_vld_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_dsp_fft_frame_feeder.sv
// Bench for dsp_fft_frame_feeder: directed scenarios plus a randomized run, all checked
// against a frame-level queue model (frames padded with zeros to FFT_N).
`timescale 1ns/1ps
module tb_dsp_fft_frame_feeder;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned FFT_N  = 8;
  localparam int unsigned LOG2N  = 3;
  localparam int unsigned SW     = 2 * DATA_W;
  localparam int unsigned BOUND  = 400;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [SW-1:0]   s_data;
  logic            s_vld;
  logic            s_last;
  logic            s_rdy;
  logic [SW-1:0]   fft_din;
  logic            fft_din_vld;
  logic            fft_din_busy;
  logic [15:0]     frame_cnt;

  dsp_fft_frame_feeder #(.DATA_W(DATA_W), .FFT_N(FFT_N), .LOG2N(LOG2N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_data       (s_data),
    .s_vld        (s_vld),
    .s_last       (s_last),
    .s_rdy        (s_rdy),
    .fft_din      (fft_din),
    .fft_din_vld  (fft_din_vld),
    .fft_din_busy (fft_din_busy),
    .frame_cnt    (frame_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            checks = 0;
  int            errors = 0;
  logic [SW-1:0] exp_q[$];
  logic [SW-1:0] cur_q[$];
  int            model_frames;
  int            acc_cyc;
  logic          rand_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, want, cyc);
    end
  endtask

  // Reference: a frame closes on s_last or at FFT_N samples and is zero-padded to FFT_N
  task automatic model_push(input logic [SW-1:0] d, input logic last);
    cur_q.push_back(d);
    if (last || cur_q.size() == FFT_N) begin
      while (cur_q.size() < FFT_N) cur_q.push_back('0);
      for (int i = 0; i < int'(FFT_N); i++) exp_q.push_back(cur_q[i]);
      cur_q.delete();
      model_frames++;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (rand_busy) fft_din_busy = ($urandom_range(0, 9) < 3);
  endtask

  // Called at a negedge; s_rdy seen here decides acceptance at the coming posedge
  task automatic send(input logic [SW-1:0] d, input logic last);
    int w;
    s_data = d;
    s_vld  = 1'b1;
    s_last = last;
    w = 0;
    while (!s_rdy && w < int'(BOUND)) begin
      tick();
      w++;
    end
    check("rdy_wait", 32'(s_rdy), 32'd1);
    acc_cyc = cyc;
    model_push(d, last);
    tick();
  endtask

  task automatic wait_vld(input string tag);
    int w;
    w = 0;
    while (!fft_din_vld && w < int'(BOUND)) begin
      tick();
      w++;
    end
    check(tag, 32'(fft_din_vld), 32'd1);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || fft_din_vld) && w < 2000) begin
      tick();
      w++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    tick();
  endtask

  // Output monitor: beat data, burst length and frame counter
  task automatic monitor();
    int run = 0;
    int frames_seen = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        run = 0;
        frames_seen = 0;
      end else if (fft_din_vld) begin
        check("beat_avail", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("beat", fft_din, exp_q.pop_front());
        run++;
      end else if (run != 0) begin
        check("burst_len", 32'(run), 32'(FFT_N));
        frames_seen++;
        check("frame_cnt", 32'(frame_cnt), 32'(16'(frames_seen)));
        run = 0;
      end
    end
  endtask

  initial begin
    int lo;
    rst_n = 1'b0;
    s_data = '0;
    s_vld = 1'b0;
    s_last = 1'b0;
    fft_din_busy = 1'b0;
    rand_busy = 1'b0;
    model_frames = 0;
    acc_cyc = 0;
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    check("rst_rdy", 32'(s_rdy), 32'd0);
    check("rst_vld", 32'(fft_din_vld), 32'd0);
    check("rst_din", fft_din, 32'd0);
    check("rst_cnt", 32'(frame_cnt), 32'd0);
    rst_n = 1'b1;
    tick();
    check("rdy_after_rst", 32'(s_rdy), 32'd1);

    // 1) full frame, latency from last accept to first beat
    for (int i = 0; i < 8; i++) send({16'd1, 16'd0}, 1'b0);
    s_vld = 1'b0;
    wait_vld("t1_vld");
    check("t1_lat", 32'(cyc - acc_cyc), 32'd3);
    drain();
    check("t1_cnt", 32'(frame_cnt), 32'd1);

    // 2) short frame closed by s_last, zero padding stalls the source
    for (int i = 0; i < 8; i++) begin
      send({16'(i), 16'(100 + i)}, (i == 4) || (i == 7));
      if (i == 4) begin
        s_vld = 1'b0;
        lo = 0;
        while (!s_rdy && lo < 20) begin
          tick();
          lo++;
        end
        check("t2_pad_cycles", 32'(lo), 32'd3);
      end
    end
    s_vld = 1'b0;
    drain();
    check("t2_cnt", 32'(frame_cnt), 32'd3);

    // 3) busy core: both banks fill, then three frames in order
    fft_din_busy = 1'b1;
    for (int i = 0; i < 16; i++) send({16'(i), 16'($urandom)}, 1'b0);
    s_vld = 1'b0;
    check("t3_rdy_full", 32'(s_rdy), 32'd0);
    repeat (6) tick();
    check("t3_no_vld", 32'(fft_din_vld), 32'd0);
    check("t3_rdy_hold", 32'(s_rdy), 32'd0);
    fft_din_busy = 1'b0;
    for (int i = 16; i < 24; i++) send({16'(i), 16'($urandom)}, 1'b0);
    s_vld = 1'b0;
    drain();
    check("t3_cnt", 32'(frame_cnt), 32'd6);

    // 4) busy raised mid-burst does not split it; next frame waits
    for (int i = 0; i < 8; i++) send(SW'($urandom), 1'b0);
    s_vld = 1'b0;
    wait_vld("t4_vld");
    fft_din_busy = 1'b1;
    for (int i = 0; i < 8; i++) send(SW'($urandom), 1'b0);
    s_vld = 1'b0;
    repeat (12) tick();
    check("t4_busy_hold", 32'(fft_din_vld), 32'd0);
    check("t4_cnt_a", 32'(frame_cnt), 32'd7);
    fft_din_busy = 1'b0;
    drain();
    check("t4_cnt_b", 32'(frame_cnt), 32'd8);

    // 5) reset in the middle of a burst
    for (int i = 0; i < 8; i++) send(SW'($urandom), 1'b0);
    s_vld = 1'b0;
    wait_vld("t5_vld");
    repeat (3) tick();
    check("t5_beat4", 32'(fft_din_vld), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_vld_drop", 32'(fft_din_vld), 32'd0);
    check("t5_cnt_clr", 32'(frame_cnt), 32'd0);
    check("t5_rdy_rst", 32'(s_rdy), 32'd0);
    exp_q.delete();
    cur_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("t5_rdy_rel", 32'(s_rdy), 32'd1);
    for (int i = 0; i < 8; i++) send(SW'($urandom), 1'b0);
    s_vld = 1'b0;
    drain();
    check("t5_cnt", 32'(frame_cnt), 32'd1);

    // 6) randomized traffic for 1000 frames
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    cur_q.delete();
    model_frames = 0;
    tick();
    rand_busy = 1'b1;
    while (model_frames < 1000) begin
      if ($urandom_range(0, 1) == 1) begin
        send(SW'($urandom), $urandom_range(0, 99) < 15);
      end else begin
        s_vld  = 1'b0;
        s_last = 1'($urandom_range(0, 1));
        s_data = SW'($urandom);
        tick();
      end
    end
    s_vld = 1'b0;
    s_last = 1'b0;
    rand_busy = 1'b0;
    fft_din_busy = 1'b0;
    drain();
    check("t6_cnt", 32'(frame_cnt), 32'd1000);
    check("t6_partial", 32'(cur_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
